// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states, ALU/mux selects.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 4'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEMADR = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEMRD  = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEMWB  = 4'd5;
  localparam logic [STATE_W-1:0] ST_MEMWR  = 4'd6;
  localparam logic [STATE_W-1:0] ST_REXEC  = 4'd7;
  localparam logic [STATE_W-1:0] ST_RWB    = 4'd8;
  localparam logic [STATE_W-1:0] ST_IEXEC  = 4'd9;
  localparam logic [STATE_W-1:0] ST_IWB    = 4'd10;
  localparam logic [STATE_W-1:0] ST_BRANCH = 4'd11;
  localparam logic [STATE_W-1:0] ST_JUMP   = 4'd12;
  localparam logic [STATE_W-1:0] ST_TRAP   = 4'd13;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH..WB per instruction,
// stalls on the memory handshake and counts retired instructions.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic               retire;
  logic               trap_entry;

  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      instret_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= state_next;
      if (retire)     instret_o <= instret_o + CNT_W'(1);
      if (trap_entry) illegal_o <= 1'b1;
    end
  end

  // Next-state and Moore/Mealy output decode; mem_ready_i only gates memory-wait states
  always_comb begin
    state_next      = state;
    retire          = 1'b0;
    trap_entry      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRC_B_REG;
    alu_op_o        = ALU_OP_ADD;
    pc_source_o     = PC_SRC_ALU;
    busy_o          = (state != ST_IDLE) && (state != ST_TRAP);

    case (state)
      ST_IDLE: begin
        if (start_i) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b_o = SRC_B_IMM_SH2;
        case (op_i)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_REXEC;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_ADDI:      state_next = ST_IEXEC;
          OP_J:         state_next = ST_JUMP;
          default: begin
            state_next = ST_TRAP;
            trap_entry = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        state_next  = (op_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        retire      = mem_ready_i;
      end
      ST_REXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_FUNCT;
        state_next  = ST_RWB;
      end
      ST_RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
      end
      ST_IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        state_next  = ST_IWB;
      end
      ST_IWB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_OP_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PC_SRC_ALUOUT;
        retire          = 1'b1;
      end
      ST_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PC_SRC_JUMP;
        retire      = 1'b1;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // start_i is only honoured at the instruction boundary
    if (retire) state_next = start_i ? ST_FETCH : ST_IDLE;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle control-word checks per instruction class.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] BAD   = 6'b111111;

  // Control word: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //                mem_to_reg, reg_dst, reg_write, src_a, src_b[1:0], alu_op[1:0], pc_src[1:0]}
  localparam logic [15:0] W_IDLE   = 16'h0000;
  localparam logic [15:0] W_FETCH  = 16'h9410;
  localparam logic [15:0] W_FWAIT  = 16'h1010;
  localparam logic [15:0] W_DECODE = 16'h0030;
  localparam logic [15:0] W_MEMADR = 16'h0060;
  localparam logic [15:0] W_MEMRD  = 16'h3000;
  localparam logic [15:0] W_MEMWB  = 16'h0280;
  localparam logic [15:0] W_MEMWR  = 16'h2800;
  localparam logic [15:0] W_REXEC  = 16'h0048;
  localparam logic [15:0] W_RWB    = 16'h0180;
  localparam logic [15:0] W_IEXEC  = 16'h0060;
  localparam logic [15:0] W_IWB    = 16'h0080;
  localparam logic [15:0] W_BRANCH = 16'h4045;
  localparam logic [15:0] W_JUMP   = 16'h8002;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [5:0]       op = 6'd0;
  logic             ready = 1'b0;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, busy, illegal;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] instret;
  logic [15:0]      ctrl;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .mem_ready_i(ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .iord_o(iord),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .busy_o(busy), .illegal_o(illegal), .instret_o(instret)
  );

  assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Memory read and write requests must never overlap
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rd_wr_excl: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    vectors++;
    if (ctrl !== W_IDLE || busy !== 1'b0 || illegal !== 1'b0 || instret !== 4'd0) begin
      errors++;
      $display("FAIL reset: ctrl=%h busy=%b illegal=%b instret=%0d required 0000/0/0/0",
               ctrl, busy, illegal, instret);
    end
    step();
  endtask

  task automatic test_rtype();
    logic [15:0] exp [4] = '{W_FETCH, W_DECODE, W_REXEC, W_RWB};
    op = RTYPE; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (ctrl !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL rtype[%0d]: ctrl=%h busy=%b required %h/1", i, ctrl, busy, exp[i]);
      end
      step();
    end
    vectors++;
    if (ctrl !== W_IDLE || busy !== 1'b0 || instret !== 4'd1) begin
      errors++;
      $display("FAIL rtype_end: ctrl=%h busy=%b instret=%0d required 0000/0/1", ctrl, busy, instret);
    end
  endtask

  task automatic test_lw_wait();
    logic [15:0] exp [8] = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMRD, W_MEMRD, W_MEMRD, W_MEMWB};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = LW; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready = rdy[i];
      #1;
      vectors++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL lw[%0d]: ctrl=%h required %h", i, ctrl, exp[i]);
      end
      step();
    end
    ready = 1'b1;
    vectors++;
    if (ctrl !== W_IDLE || instret !== 4'd2) begin
      errors++;
      $display("FAIL lw_end: ctrl=%h instret=%0d required 0000/2", ctrl, instret);
    end
  endtask

  task automatic test_fetch_wait();
    logic [15:0] exp [7] = '{W_FWAIT, W_FWAIT, W_FETCH, W_DECODE, W_MEMADR, W_MEMWR, W_MEMWR};
    logic        rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int ir_pulses = 0;
    int pc_pulses = 0;
    op = SW; start = 1'b1; ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ready = rdy[i];
      #1;
      vectors++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL sw_fwait[%0d]: ctrl=%h required %h", i, ctrl, exp[i]);
      end
      ir_pulses += int'(ir_write);
      pc_pulses += int'(pc_write);
      step();
    end
    vectors++;
    if (ir_pulses != 1 || pc_pulses != 1) begin
      errors++;
      $display("FAIL fetch_pulses: ir_write=%0d pc_write=%0d required 1/1", ir_pulses, pc_pulses);
    end
    vectors++;
    if (ctrl !== W_IDLE || instret !== 4'd3) begin
      errors++;
      $display("FAIL sw_end: ctrl=%h instret=%0d required 0000/3", ctrl, instret);
    end
  endtask

  task automatic test_beq_stop();
    logic [15:0] exp [3] = '{W_FETCH, W_DECODE, W_BRANCH};
    op = BEQ; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL beq[%0d]: ctrl=%h required %h", i, ctrl, exp[i]);
      end
      step();
    end
    step();
    vectors++;
    if (ctrl !== W_IDLE || busy !== 1'b0 || instret !== 4'd4) begin
      errors++;
      $display("FAIL beq_end: ctrl=%h busy=%b instret=%0d required 0000/0/4", ctrl, busy, instret);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [7] = '{W_FETCH, W_DECODE, W_IEXEC, W_IWB, W_FETCH, W_DECODE, W_JUMP};
    logic [5:0]  ops [7] = '{ADDI, ADDI, ADDI, ADDI, JMP, JMP, JMP};
    logic [3:0]  cnt [7] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5};
    start = 1'b1; ready = 1'b1; op = ADDI;
    step();
    for (int i = 0; i < 7; i++) begin
      op = ops[i];
      if (i == 6) start = 1'b0;
      #1;
      vectors++;
      if (ctrl !== exp[i] || instret !== cnt[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: ctrl=%h instret=%0d required %h/%0d", i, ctrl, instret, exp[i], cnt[i]);
      end
      step();
    end
    vectors++;
    if (ctrl !== W_IDLE || instret !== 4'd6) begin
      errors++;
      $display("FAIL b2b_end: ctrl=%h instret=%0d required 0000/6", ctrl, instret);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt = 4'd6;
    op = JMP; start = 1'b1; ready = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      step(); step();
      if (k == 9) start = 1'b0;
      #1;
      vectors++;
      if (ctrl !== W_JUMP) begin
        errors++;
        $display("FAIL wrap_jump[%0d]: ctrl=%h required %h", k, ctrl, W_JUMP);
      end
      step();
      exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (instret !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_cnt[%0d]: instret=%0d required %0d", k, instret, exp_cnt);
      end
    end
    vectors++;
    if (instret !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: instret=%0d busy=%b required 0/0", instret, busy);
    end
  endtask

  task automatic test_trap();
    op = BAD; start = 1'b1; ready = 1'b1;
    step(); step();
    #1;
    vectors++;
    if (ctrl !== W_DECODE || illegal !== 1'b0) begin
      errors++;
      $display("FAIL trap_decode: ctrl=%h illegal=%b required %h/0", ctrl, illegal, W_DECODE);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ctrl !== W_IDLE || busy !== 1'b0 || illegal !== 1'b1 || instret !== 4'd0) begin
        errors++;
        $display("FAIL trap_hold[%0d]: ctrl=%h busy=%b illegal=%b instret=%0d required 0000/0/1/0",
                 i, ctrl, busy, illegal, instret);
      end
      step();
    end
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
    vectors++;
    if (illegal !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL trap_clear: illegal=%b busy=%b required 0/0", illegal, busy);
    end
  endtask

  task automatic test_reset_memwr();
    op = SW; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    ready = 1'b1;
    step();
    // Sit in MEMWR for one retired SW to get a nonzero count, then repeat and reset mid-write
    start = 1'b1; op = SW;
    step();
    step(); step();
    ready = 1'b0;
    step();
    #1;
    vectors++;
    if (ctrl !== W_MEMWR || instret !== 4'd1) begin
      errors++;
      $display("FAIL memwr_wait: ctrl=%h instret=%0d required %h/1", ctrl, instret, W_MEMWR);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    vectors++;
    if (ctrl !== W_IDLE || mem_write !== 1'b0 || instret !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL memwr_reset: ctrl=%h mem_write=%b instret=%0d busy=%b required 0000/0/0/0",
               ctrl, mem_write, instret, busy);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_wait();
    test_beq_stop();
    test_back_to_back();
    test_wrap();
    test_trap();
    test_reset_memwr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
